tlb_refill_ctrl: RTL and testbench

TLB_REFILL_CTRL -- requirements
Module: tlb_refill_ctrl

---
 rtl/tlb_pkg.sv | 7 +
 rtl/tlb_rr_arb.sv | 14 +
 rtl/tlb_refill_ctrl.sv | 122 ++++++++++++
 tb/tb_tlb_refill_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared FSM state encoding and default address/page/PCID widths for the TLB refill controller
package tlb_pkg;
  localparam int SADDR_DEF = 64;
  localparam int SPAGE_DEF = 12;
  localparam int SPCID_DEF = 12;
  typedef enum logic [2:0] {IDLE, LOOKUP, WALK_REQ, WALK_WAIT, INSERT, RESP, FLUSH} state_t;
endpackage

// File: rtl/tlb_rr_arb.sv
// tlb_rr_arb: 2-way round-robin arbiter (clk, rst, en, req[1:0] -> gnt[1:0]); last-granted port loses ties, port 0 favoured after rst
module tlb_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;
  always_comb gnt = !en ? 2'b00 : (&req) ? (last ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= 1'b1;
    else if (|gnt) last <= gnt[1];
endmodule

// File: rtl/tlb_refill_ctrl.sv
// tlb_refill_ctrl: TLB lookup/refill FSM; ports req_*/rsp_* (2-port requests), tlb_* (lookup/insert/shutdown), walk_* (page walker), flush/flush_done; define TLB_CTRL_PERF_EN for perf_hit/perf_miss/perf_fault counters
module tlb_refill_ctrl
  import tlb_pkg::*;
#(
  parameter int SADDR     = SADDR_DEF,
  parameter int SPAGE     = SPAGE_DEF,
  parameter int SPCID     = SPCID_DEF,
  parameter int LKP_TO    = 4,
  parameter int FLUSH_CYC = 3
) (
  input  logic [1:0]         req_valid,
  input  logic               clk,
  input  logic               rst,
  output logic [1:0]         req_ready,
  input  logic [2*SADDR-1:0] req_va,
  input  logic [2*SPCID-1:0] req_pcid,
  output logic [1:0]         rsp_valid,
  output logic [SADDR-1:0]   rsp_pa,
  output logic               rsp_fault,
  input  logic               flush,
  output logic               flush_done,
  output logic [SADDR-1:0]   tlb_va,
  output logic [SPCID-1:0]   tlb_pcid,
  output logic [SADDR-1:0]   tlb_pa,
  output logic               tlb_insert,
  output logic               tlb_shutdown,
  input  logic               tlb_hit,
  input  logic               tlb_miss,
  input  logic [SADDR-1:0]   tlb_ta,
  output logic               walk_valid,
  input  logic               walk_ready,
  output logic [SADDR-1:0]   walk_va,
  output logic [SPCID-1:0]   walk_pcid,
  input  logic               walk_rsp_valid,
  input  logic [SADDR-1:0]   walk_rsp_pa,
  input  logic               walk_rsp_fault
`ifdef TLB_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_hit,
  output logic [31:0]        perf_miss,
  output logic [31:0]        perf_fault
`endif
);
  localparam int CMAX = LKP_TO > FLUSH_CYC ? LKP_TO : FLUSH_CYC;
  localparam int CW = $clog2(CMAX + 1) + 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [SADDR-1:0] va_q, pa_q, sel_va;
  logic [SPCID-1:0] pcid_q, sel_pcid;
  logic [1:0] gnt;
  logic port_q, hit_q, fault_q;
  tlb_rr_arb u_arb (.clk(clk), .rst(rst), .en(state == IDLE && !flush && !rst), .req(req_valid), .gnt(gnt));
  assign sel_va = gnt[1] ? req_va[SADDR +: SADDR] : req_va[0 +: SADDR];
  assign sel_pcid = gnt[1] ? req_pcid[SPCID +: SPCID] : req_pcid[0 +: SPCID];
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = flush ? FLUSH : (|gnt) ? LOOKUP : IDLE;
      LOOKUP:    nxt = tlb_hit ? RESP : (tlb_miss || cnt == CW'(LKP_TO - 1)) ? WALK_REQ : LOOKUP;
      WALK_REQ:  nxt = walk_ready ? WALK_WAIT : WALK_REQ;
      WALK_WAIT: nxt = !walk_rsp_valid ? WALK_WAIT : walk_rsp_fault ? RESP : INSERT;
      INSERT:    nxt = RESP;
      RESP:      nxt = IDLE;
      FLUSH:     nxt = cnt == CW'(FLUSH_CYC) ? IDLE : FLUSH;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      va_q    <= '0;
      pcid_q  <= '0;
      pa_q    <= '0;
      port_q  <= 1'b0;
      hit_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? '0 : cnt + 1'b1;
      if (|gnt) begin
        va_q    <= sel_va;
        pcid_q  <= sel_pcid;
        port_q  <= gnt[1];
        hit_q   <= 1'b0;
        fault_q <= 1'b0;
      end
      if (state == LOOKUP && tlb_hit) begin
        pa_q  <= tlb_ta;
        hit_q <= 1'b1;
      end
      if (state == WALK_WAIT && walk_rsp_valid) begin
        pa_q    <= walk_rsp_pa;
        fault_q <= walk_rsp_fault;
      end
    end
  assign req_ready    = gnt;
  assign tlb_va       = state == IDLE ? ((|gnt) ? sel_va : '0) : va_q;
  assign tlb_pcid     = state == IDLE ? ((|gnt) ? sel_pcid : '0) : pcid_q;
  assign tlb_insert   = state == INSERT;
  assign tlb_pa       = tlb_insert ? pa_q : '0;
  assign tlb_shutdown = state == IDLE && flush && !rst;
  assign flush_done   = state == FLUSH && cnt == CW'(FLUSH_CYC);
  assign walk_valid   = state == WALK_REQ;
  assign walk_va      = va_q;
  assign walk_pcid    = pcid_q;
  assign rsp_valid    = state != RESP ? 2'b00 : port_q ? 2'b10 : 2'b01;
  assign rsp_fault    = state == RESP && fault_q;
  assign rsp_pa       = state != RESP ? '0 : hit_q ? pa_q : {pa_q[SADDR-1:SPAGE], va_q[SPAGE-1:0]};
`ifdef TLB_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_hit   <= '0;
      perf_miss  <= '0;
      perf_fault <= '0;
    end else if (state == RESP) begin
      if (hit_q && !(&perf_hit)) perf_hit <= perf_hit + 32'd1;
      if (!hit_q && !fault_q && !(&perf_miss)) perf_miss <= perf_miss + 32'd1;
      if (fault_q && !(&perf_fault)) perf_fault <= perf_fault + 32'd1;
    end
`endif
endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// tb_tlb_refill_ctrl: table-driven vectors plus hand sequences, responses checked against a scoreboard queue
module tb_tlb_refill_ctrl;
  localparam int SADDR = 64;
  localparam int SPCID = 12;
  logic clk = 1'b0, rst;
  logic [1:0] req_valid, req_ready, rsp_valid;
  logic [2*SADDR-1:0] req_va;
  logic [2*SPCID-1:0] req_pcid;
  logic [SADDR-1:0] rsp_pa, tlb_va, tlb_pa, tlb_ta, walk_va, walk_rsp_pa;
  logic [SPCID-1:0] tlb_pcid, walk_pcid;
  logic rsp_fault, flush, flush_done, tlb_insert, tlb_shutdown, tlb_hit, tlb_miss;
  logic walk_valid, walk_ready, walk_rsp_valid, walk_rsp_fault, any_out;
  int n_vec = 0, n_err = 0, cyc = 0, ins_cnt = 0, exp_ins = 0;
  typedef struct {bit port; logic [63:0] pa; bit chkpa; bit fault; int gcyc; int lat;} exp_t;
  typedef struct {
    bit port; logic [63:0] va; logic [11:0] pcid; int hdelay; logic [1:0] ev; logic [63:0] ta;
    int wdelay; logic [63:0] wpa; bit wfault; bit stray; logic [63:0] exp_pa; int lat;
  } vec_t;
  exp_t q[$];
  exp_t e;
  vec_t tbl[8];
  tlb_refill_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va),
    .req_pcid(req_pcid), .rsp_valid(rsp_valid), .rsp_pa(rsp_pa), .rsp_fault(rsp_fault),
    .flush(flush), .flush_done(flush_done), .tlb_va(tlb_va), .tlb_pcid(tlb_pcid), .tlb_pa(tlb_pa),
    .tlb_insert(tlb_insert), .tlb_shutdown(tlb_shutdown), .tlb_hit(tlb_hit), .tlb_miss(tlb_miss),
    .tlb_ta(tlb_ta), .walk_valid(walk_valid), .walk_ready(walk_ready), .walk_va(walk_va),
    .walk_pcid(walk_pcid), .walk_rsp_valid(walk_rsp_valid), .walk_rsp_pa(walk_rsp_pa),
    .walk_rsp_fault(walk_rsp_fault)
  );
  assign any_out = |{req_ready, rsp_valid, rsp_pa, rsp_fault, flush_done, tlb_va, tlb_pcid, tlb_pa,
                     tlb_insert, tlb_shutdown, walk_valid, walk_va, walk_pcid};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (tlb_insert) ins_cnt <= ins_cnt + 1;
      if (rsp_valid != 2'b00) begin
        if (q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        else begin
          e = q.pop_front();
          check("rsp_valid", 64'(rsp_valid), e.port ? 64'd2 : 64'd1);
          if (e.chkpa) check("rsp_pa", rsp_pa, e.pa);
          check("rsp_fault", 64'(rsp_fault), 64'(e.fault));
          check("rsp_latency", 64'(cyc - e.gcyc), 64'(e.lat));
        end
      end
    end
  end
  task automatic wait_grant(input logic [1:0] eg, input logic [63:0] va, input logic [11:0] pcid,
                            input logic [63:0] pa, input bit chkpa, input bit fault, input int lat);
    bit got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        got = 1'b1;
        check("req_ready", 64'(req_ready), 64'(eg));
        check("tlb_va_at_grant", tlb_va, va);
        check("tlb_pcid_at_grant", 64'(tlb_pcid), 64'(pcid));
        q.push_back('{eg[1], pa, chkpa, fault, cyc, lat});
      end
    end
    if (!got) check("grant_timeout", 64'(req_ready), 64'(eg));
  endtask
  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    req_valid = v.port ? 2'b10 : 2'b01;
    req_va = v.port ? {v.va, ~v.va} : {~v.va, v.va};
    req_pcid = v.port ? {v.pcid, ~v.pcid} : {~v.pcid, v.pcid};
    wait_grant(req_valid, v.va, v.pcid, v.exp_pa, !v.wfault, v.wfault, v.lat);
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int k = 0; k < v.hdelay; k++) begin
      @(negedge clk);
      check("walk_valid_in_lookup", 64'(walk_valid), 64'd0);
      @(posedge clk); #1;
    end
    if (v.ev != 2'b00) begin
      tlb_hit = v.ev[0];
      tlb_miss = v.ev[1];
      tlb_ta = v.ta;
      @(posedge clk); #1;
      tlb_hit = 1'b0;
      tlb_miss = 1'b0;
    end
    if (!v.ev[0]) begin
      for (int k = 0; k <= v.wdelay; k++) begin
        tlb_hit = v.stray;
        walk_ready = (k == v.wdelay);
        @(negedge clk);
        check("walk_valid", 64'(walk_valid), 64'd1);
        check("walk_va_stable", walk_va, v.va);
        check("walk_pcid", 64'(walk_pcid), 64'(v.pcid));
        @(posedge clk); #1;
      end
      tlb_hit = 1'b0;
      walk_ready = 1'b0;
      walk_rsp_valid = 1'b1;
      walk_rsp_pa = v.wpa;
      walk_rsp_fault = v.wfault;
      @(posedge clk); #1;
      walk_rsp_valid = 1'b0;
      walk_rsp_fault = 1'b0;
      @(negedge clk);
      check("tlb_insert", 64'(tlb_insert), 64'(!v.wfault));
      if (!v.wfault) check("tlb_pa", tlb_pa, v.wpa);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{0, 64'h1000_0123, 12'h001, 0, 2'b01, 64'h8000_5123, 0, 64'h0, 0, 0, 64'h8000_5123, 2};
    tbl[1] = '{1, 64'h2000_0123, 12'h002, 0, 2'b10, 64'h0, 3, 64'hABCD_E000, 0, 1, 64'hABCD_E123, 8};
    tbl[2] = '{0, 64'h3000_0456, 12'h003, 4, 2'b00, 64'h0, 0, 64'h1234_5000, 0, 0, 64'h1234_5456, 8};
    tbl[3] = '{1, 64'h4000_0789, 12'h004, 0, 2'b10, 64'h0, 0, 64'h9999_9000, 1, 0, 64'h0, 4};
    tbl[4] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 12'hFFF, 0, 2'b01, 64'h0, 0, 64'h0, 0, 0, 64'h0, 2};
    tbl[5] = '{1, 64'h5555_0FFF, 12'h005, 0, 2'b10, 64'h0, 0, 64'h7777_7ABC, 0, 0, 64'h7777_7FFF, 5};
    tbl[6] = '{0, 64'h6000_0010, 12'h006, 3, 2'b01, 64'hC0DE_0010, 0, 64'h0, 0, 0, 64'hC0DE_0010, 5};
    tbl[7] = '{1, 64'h7000_0020, 12'h007, 0, 2'b11, 64'hBEEF_0020, 0, 64'hDEAD_0000, 0, 0, 64'hBEEF_0020, 2};
    rst = 1'b1;
    req_valid = 2'b11;
    req_va = {64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321};
    req_pcid = 24'hABC_DEF;
    flush = 1'b1;
    tlb_hit = 1'b1;
    tlb_miss = 1'b0;
    tlb_ta = 64'h0;
    walk_ready = 1'b0;
    walk_rsp_valid = 1'b0;
    walk_rsp_pa = 64'h0;
    walk_rsp_fault = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'(any_out), 64'd0);
    req_valid = 2'b00;
    flush = 1'b0;
    tlb_hit = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_quiet", 64'(any_out), 64'd0);
    @(posedge clk); #1;
    req_valid = 2'b11;
    req_va = {64'h1111_0000_0000_0111, 64'h2222_0000_0000_0222};
    req_pcid = {12'h111, 12'h222};
    for (int k = 0; k < 4; k++) begin
      logic [1:0] eg;
      logic [63:0] ta;
      eg = k[0] ? 2'b10 : 2'b01;
      ta = 64'hA000_0000 | 64'(k);
      wait_grant(eg, eg[1] ? 64'h1111_0000_0000_0111 : 64'h2222_0000_0000_0222,
                 eg[1] ? 12'h111 : 12'h222, ta, 1'b1, 1'b0, 2);
      @(posedge clk); #1;
      if (k == 3) req_valid = 2'b00;
      tlb_hit = 1'b1;
      tlb_ta = ta;
      @(posedge clk); #1;
      tlb_hit = 1'b0;
    end
    foreach (tbl[i]) begin
      run_vec(tbl[i]);
      if (!tbl[i].ev[0] && !tbl[i].wfault) exp_ins++;
    end
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_va = {~64'h0800_0ABC, 64'h0800_0ABC};
    req_pcid = {12'h0F0, 12'h00F};
    wait_grant(2'b01, 64'h0800_0ABC, 12'h00F, 64'h0F00_0ABC, 1'b1, 1'b0, 6);
    @(posedge clk); #1;
    req_valid = 2'b00;
    tlb_miss = 1'b1;
    @(posedge clk); #1;
    tlb_miss = 1'b0;
    walk_ready = 1'b1;
    @(posedge clk); #1;
    walk_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("no_shutdown_walk_wait", 64'(tlb_shutdown), 64'd0);
    @(posedge clk); #1;
    walk_rsp_valid = 1'b1;
    walk_rsp_pa = 64'h0F00_0000;
    @(negedge clk);
    check("no_shutdown_walk_rsp", 64'(tlb_shutdown), 64'd0);
    @(posedge clk); #1;
    walk_rsp_valid = 1'b0;
    @(negedge clk);
    check("no_shutdown_insert", 64'(tlb_shutdown), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("no_shutdown_resp", 64'(tlb_shutdown), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("shutdown_after_resp", 64'(tlb_shutdown), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("flush_done_timing", 64'(flush_done), 64'(k == 4));
    end
    exp_ins++;
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_va = {64'h0, 64'h0900_0001};
    req_pcid = {12'h0, 12'h009};
    wait_grant(2'b01, 64'h0900_0001, 12'h009, 64'h0, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    tlb_miss = 1'b1;
    @(posedge clk); #1;
    tlb_miss = 1'b0;
    @(negedge clk);
    check("walk_valid_before_rst", 64'(walk_valid), 64'd1);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    check("rst_mid_walk_outputs", 64'(any_out), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    walk_rsp_valid = 1'b1;
    walk_rsp_pa = 64'h0BAD_0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_quiet", 64'({rsp_valid, tlb_insert, walk_valid}), 64'd0);
      @(posedge clk); #1;
      if (k == 1) walk_rsp_valid = 1'b0;
    end
    req_valid = 2'b11;
    req_va = {64'h0000_0000_0333_0333, 64'h0000_0000_0444_0444};
    req_pcid = {12'h333, 12'h444};
    wait_grant(2'b01, 64'h0000_0000_0444_0444, 12'h444, 64'h5555_0444, 1'b1, 1'b0, 2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    tlb_hit = 1'b1;
    tlb_ta = 64'h5555_0444;
    @(posedge clk); #1;
    tlb_hit = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    check("insert_count", 64'(ins_cnt), 64'(exp_ins));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
